// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter: state encoding and
// the default memory geometry used by the memory unit.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_e;

  // Locked state owned by the given port.
  function automatic arb_state_e lock_state(input logic port);
    return port ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: decides which master owns the memory port
// this cycle from the requests, the last winner and the lock state.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  arb_state_e state,
  output logic       gnt0,
  output logic       gnt1
);

  // Grant selection; a locked state shuts out the other master entirely.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      ARB: begin
        if (req0 && req1) begin
          if (FIXED_PRIO != 0) begin
            gnt0 = 1'b1;
          end else begin
            gnt0 = last;
            gnt1 = ~last;
          end
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      LOCK0:   gnt0 = req0;
      LOCK1:   gnt1 = req1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single main-memory port, with lock support for
// atomic read-modify-write and a fixed one-cycle read return path.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_HOLD   = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_e        state_r, state_nxt_s;
  logic              last_r, last_nxt_s;
  logic [HOLD_W-1:0] hold_r, hold_nxt_s;
  logic              pick_g0_s, pick_g1_s;
  logic              rtag0_r, rtag1_r;
  logic [DATA_W-1:0] rhold0_r, rhold1_r;

  mem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_r),
    .state (state_r),
    .gnt0  (pick_g0_s),
    .gnt1  (pick_g1_s)
  );

  assign gnt0   = pick_g0_s & ~rst;
  assign gnt1   = pick_g1_s & ~rst;
  assign mem_en = gnt0 | gnt1;

  // Pending reads are dropped by reset; rdata holds until the next return.
  assign rvalid0 = rtag0_r & ~rst;
  assign rvalid1 = rtag1_r & ~rst;
  assign rdata0  = rvalid0 ? mem_rdata : rhold0_r;
  assign rdata1  = rvalid1 ? mem_rdata : rhold1_r;

  // Memory bus mux from the granted master.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Next state, last winner and lock hold count.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    hold_nxt_s  = hold_r;
    if (gnt0) begin
      last_nxt_s = 1'b0;
    end else if (gnt1) begin
      last_nxt_s = 1'b1;
    end else begin
      last_nxt_s = last_r;
    end
    case (state_r)
      ARB: begin
        if ((gnt0 && lock0) || (gnt1 && lock1)) begin
          hold_nxt_s  = HOLD_ONE;
          // A single-access budget is already spent by the winning grant.
          state_nxt_s = (HOLD_ONE == HOLD_MAX) ? ARB : lock_state(gnt1);
        end else begin
          hold_nxt_s  = {HOLD_W{1'b0}};
          state_nxt_s = ARB;
        end
      end
      LOCK0: begin
        if (gnt0 && (hold_r != HOLD_MAX)) begin
          hold_nxt_s = hold_r + HOLD_ONE;
        end else begin
          hold_nxt_s = hold_r;
        end
        if (!lock0 || (hold_nxt_s == HOLD_MAX)) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = LOCK0;
        end
      end
      LOCK1: begin
        if (gnt1 && (hold_r != HOLD_MAX)) begin
          hold_nxt_s = hold_r + HOLD_ONE;
        end else begin
          hold_nxt_s = hold_r;
        end
        if (!lock1 || (hold_nxt_s == HOLD_MAX)) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = LOCK1;
        end
      end
      default: begin
        state_nxt_s = ARB;
        hold_nxt_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State, hold counter and read-return tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ARB;
      last_r   <= 1'b1;
      hold_r   <= {HOLD_W{1'b0}};
      rtag0_r  <= 1'b0;
      rtag1_r  <= 1'b0;
      rhold0_r <= {DATA_W{1'b0}};
      rhold1_r <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      last_r   <= last_nxt_s;
      hold_r   <= hold_nxt_s;
      rtag0_r  <= gnt0 & ~we0;
      rtag1_r  <= gnt1 & ~we1;
      rhold0_r <= rdata0;
      rhold1_r <= rdata1;
    end
  end

endmodule
